// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and constants for the RV32M multiply/divide unit.
// Op encodings follow funct3; state enum drives the muldiv_unit FSM.
package muldiv_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [XLEN-1:0] DIV_BY_ZERO_Q = '1;
  localparam logic [XLEN-1:0] INT_MIN =
    {1'b1, {(XLEN-1){1'b0}}};

  function automatic logic is_div(input op_e op);
    return op[2];
  endfunction

endpackage

// File: rtl/muldiv_unit_div_step.sv
// div_step: one combinational restoring-division step.
// In: rem, quotient (dividend bits shift out MSB first), divisor. Out: rem_next, quotient_next.
module div_step #(
  parameter int W = 32
) (
  input  logic [W-1:0] rem,
  input  logic [W-1:0] quotient,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] rem_next,
  output logic [W-1:0] quotient_next
);

  logic [W:0] shifted;
  logic [W:0] diff;

  assign shifted = {rem, quotient[W-1]};
  assign diff    = shifted - {1'b0, divisor};

  // diff[W] set means the trial subtract borrowed: restore.
  assign rem_next      = diff[W] ? shifted[W-1:0]
                                 : diff[W-1:0];
  assign quotient_next = {quotient[W-2:0], ~diff[W]};

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M mul/div (1 bit/cycle), valid/ready in, 1-cycle resp_valid out.
// Ports: clk, rst_n, req_valid/req_ready, Operation, SrcA, SrcB, flush, busy, resp_valid, MDResult.
// MULDIV_FAST_MUL_EN: MUL* done by one combinational multiply at accept.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int DATA_WIDTH    = XLEN,
  parameter int OPCODE_LENGTH = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [OPCODE_LENGTH-1:0] Operation,
  input  logic [DATA_WIDTH-1:0]    SrcA,
  input  logic [DATA_WIDTH-1:0]    SrcB,
  input  logic                     flush,
  output logic                     busy,
  output logic                     resp_valid,
  output logic [DATA_WIDTH-1:0]    MDResult
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W);

  state_e         state, state_n;
  op_e            op_in, op_q;
  logic [CW-1:0]  count;
  logic [W-1:0]   opnd_q;
  logic [2*W-1:0] acc, acc_n, prod;
  logic           neg_q;
  logic           sa, sb, div_in, div_zero, ovf;
  logic           quick, accept, last;
  logic [W-1:0]   amag, bmag, quick_res, fin;
  logic [W-1:0]   qs, rs, rem_next, quo_next;
  logic [W:0]     sum;

  assign op_in  = op_e'(Operation);
  assign div_in = is_div(op_in);

  assign sa = SrcA[W-1] & (op_in inside
    {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
  assign sb = SrcB[W-1] & (op_in inside
    {OP_MUL, OP_MULH, OP_DIV, OP_REM});

  assign amag = sa ? -SrcA : SrcA;
  assign bmag = sb ? -SrcB : SrcB;

  assign div_zero = div_in & (SrcB == '0);
  assign ovf = (op_in inside {OP_DIV, OP_REM})
             & (SrcA == INT_MIN) & (&SrcB);

`ifdef MULDIV_FAST_MUL_EN
  logic [2*W-1:0] fprod;
  // Sign-extended to 2W so the truncated product is exact.
  assign fprod = {{W{sa}}, SrcA} * {{W{sb}}, SrcB};
  assign quick = ~div_in | div_zero | ovf;
`else
  assign quick = div_zero | ovf;
`endif

  always_comb begin
    quick_res = '0;
    unique case (1'b1)
`ifdef MULDIV_FAST_MUL_EN
      ~div_in:
        quick_res = (op_in == OP_MUL) ? fprod[W-1:0]
                                      : fprod[2*W-1:W];
`endif
      div_zero & ~op_in[1]: quick_res = DIV_BY_ZERO_Q;
      div_zero &  op_in[1]: quick_res = SrcA;
      ovf & ~op_in[1]:      quick_res = INT_MIN;
      default:              quick_res = '0;
    endcase
  end

  assign accept = (state == IDLE) & req_valid & ~flush;
  assign last   = (count == CW'(W-1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (accept) state_n = quick ? DONE : BUSY;
      BUSY: begin
        if (flush)     state_n = IDLE;
        else if (last) state_n = DONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign req_ready  = (state == IDLE);
  assign busy       = (state != IDLE);
  assign resp_valid = (state == DONE) & ~flush;

  div_step #(.W(W)) u_div_step (
    .rem           (acc[2*W-1:W]),
    .quotient      (acc[W-1:0]),
    .divisor       (opnd_q),
    .rem_next      (rem_next),
    .quotient_next (quo_next)
  );

  // Shift-add: high half accumulates, multiplier drains from bit 0.
  assign sum = {1'b0, acc[2*W-1:W]}
             + (acc[0] ? {1'b0, opnd_q} : '0);

  assign acc_n = is_div(op_q) ? {rem_next, quo_next}
                              : {sum, acc[W-1:1]};

  assign prod = neg_q ? -acc_n : acc_n;
  assign qs   = neg_q ? -acc_n[W-1:0] : acc_n[W-1:0];
  assign rs   = neg_q ? -acc_n[2*W-1:W]
                      : acc_n[2*W-1:W];

  always_comb begin
    fin = rs;
    unique case (1'b1)
      op_q == OP_MUL:               fin = prod[W-1:0];
      ~op_q[2] & (op_q != OP_MUL):  fin = prod[2*W-1:W];
      op_q[2] & ~op_q[1]:           fin = qs;
      default:                      fin = rs;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= OP_MUL;
      count    <= '0;
      opnd_q   <= '0;
      acc      <= '0;
      neg_q    <= 1'b0;
      MDResult <= '0;
    end else if (accept) begin
      op_q   <= op_in;
      count  <= '0;
      opnd_q <= div_in ? bmag : amag;
      acc    <= {{W{1'b0}}, div_in ? amag : bmag};
      // REM follows the dividend sign; others use the XOR.
      neg_q  <= (div_in & op_in[1]) ? sa : (sa ^ sb);
      if (quick) MDResult <= quick_res;
    end else if ((state == BUSY) & ~flush) begin
      acc   <= acc_n;
      count <= count + 1'b1;
      if (last) MDResult <= fin;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench for muldiv_unit with an arithmetic reference model.
// Directed RV32M corner cases, random ops, flush, and mid-op reset.
module tb_muldiv_unit;
  import muldiv_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  Operation;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic        flush;
  logic        busy;
  logic        resp_valid;
  logic [31:0] MDResult;

  muldiv_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .Operation  (Operation),
    .SrcA       (SrcA),
    .SrcB       (SrcB),
    .flush      (flush),
    .busy       (busy),
    .resp_valid (resp_valid),
    .MDResult   (MDResult)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          acc;
    int          lat;
  } exp_t;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
  } vec_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  logic [31:0] last_res = '0;

  function automatic logic [31:0] ref_model(
    input logic [2:0] op, input logic [31:0] a,
    input logic [31:0] b);
    longint          p;
    longint unsigned pu;
    int              ia;
    int              ib;
    bit              ov;
    ia = a;
    ib = b;
    ov = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      3'b000: begin p = longint'(ia) * longint'(ib); return p[31:0]; end
      3'b001: begin p = longint'(ia) * longint'(ib); return p[63:32]; end
      3'b010: begin p = longint'(ia) * longint'({32'h0, b}); return p[63:32]; end
      3'b011: begin pu = {32'h0, a} * {32'h0, b}; return pu[63:32]; end
      3'b100: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ov) return 32'h8000_0000;
        return ia / ib;
      end
      3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110: begin
        if (b == 0) return a;
        if (ov) return 32'h0;
        return ia % ib;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Clock edges from the accept edge to the edge that raises resp_valid.
  function automatic int lat_model(
    input logic [2:0] op, input logic [31:0] a,
    input logic [31:0] b);
    bit ov;
    ov = !op[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    if (op[2] && (b == 0 || ov)) return 0;
    if (!op[2] && FAST) return 0;
    return 32;
  endfunction

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       input logic [31:0] res,
                       input bit push);
    int   guard = 0;
    exp_t e;
    @(negedge clk);
    req_valid = 1'b1;
    Operation = op;
    SrcA      = a;
    SrcB      = b;
    while (!req_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) begin
      checks++;
      fails++;
      $display("FAIL accept_timeout op=%0d got=%0d exp=1", op, req_ready);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    if (push) begin
      e.op  = op;
      e.a   = a;
      e.b   = b;
      e.res = res;
      e.acc = cyc;
      e.lat = lat_model(op, a, b);
      sb_q.push_back(e);
    end
  endtask

  task automatic drain();
    int guard = 0;
    while ((sb_q.size() != 0 || busy) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk("drain_pending", sb_q.size(), 0);
  endtask

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return $urandom_range(0, 15);
      default: return $urandom;
    endcase
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      last_res = '0;
    end else if (resp_valid) begin
      if (sb_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_resp got=%h exp=none", MDResult);
      end else begin
        mon_e = sb_q.pop_front();
        checks++;
        if (MDResult !== mon_e.res) begin
          fails++;
          $display("FAIL result op=%0d a=%h b=%h got=%h exp=%h",
                   mon_e.op, mon_e.a, mon_e.b, MDResult, mon_e.res);
        end
        checks++;
        if (cyc - mon_e.acc != mon_e.lat) begin
          fails++;
          $display("FAIL latency op=%0d got=%0d exp=%0d",
                   mon_e.op, cyc - mon_e.acc, mon_e.lat);
        end
      end
      last_res = MDResult;
    end else begin
      checks++;
      if (MDResult !== last_res) begin
        fails++;
        $display("FAIL result_hold got=%h exp=%h", MDResult, last_res);
      end
    end
  end

  vec_t dir [14] = '{
    '{3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB},
    '{3'b001, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000},
    '{3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE},
    '{3'b010, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF},
    '{3'b100, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD},
    '{3'b110, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF},
    '{3'b101, 32'd100,        32'd7,         32'd14},
    '{3'b111, 32'd100,        32'd7,         32'd2},
    '{3'b100, 32'd5,          32'd0,         32'hFFFF_FFFF},
    '{3'b110, 32'd5,          32'd0,         32'd5},
    '{3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000},
    '{3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0},
    '{3'b101, 32'd5,          32'd0,         32'hFFFF_FFFF},
    '{3'b111, 32'd5,          32'd0,         32'd5}
  };

  logic [31:0] held;
  logic [31:0] ra;
  logic [31:0] rb;
  logic [2:0]  rop;

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    flush     = 1'b0;
    Operation = '0;
    SrcA      = '0;
    SrcB      = '0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_result", MDResult, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", req_ready, 1);

    foreach (dir[i])
      issue(dir[i].op, dir[i].a, dir[i].b, dir[i].res, 1'b1);

    for (int i = 0; i < 60; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = rnd_opnd();
      rb  = rnd_opnd();
      issue(rop, ra, rb, ref_model(rop, ra, rb), 1'b1);
    end
    drain();

    held = MDResult;
    issue(3'b101, 32'd1000, 32'd3, 32'd0, 1'b0);
    repeat (5) @(negedge clk);
    req_valid = 1'b1;
    Operation = 3'b000;
    SrcA      = 32'd3;
    SrcB      = 32'd4;
    chk("ready_while_busy", req_ready, 0);
    chk("busy_while_busy", busy, 1);
    repeat (6) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush     = 1'b0;
    req_valid = 1'b0;
    chk("flush_busy", busy, 0);
    chk("flush_ready", req_ready, 1);
    chk("flush_no_resp", resp_valid, 0);
    chk("flush_result_kept", MDResult, held);
    repeat (40) @(negedge clk);
    chk("flush_stays_idle", busy, 0);

    @(negedge clk);
    flush     = 1'b1;
    req_valid = 1'b1;
    Operation = 3'b101;
    SrcA      = 32'd50;
    SrcB      = 32'd5;
    @(posedge clk);
    #1;
    flush     = 1'b0;
    req_valid = 1'b0;
    chk("flush_blocks_accept", busy, 0);
    repeat (40) @(negedge clk);

    issue(3'b101, 32'd100, 32'd7, 32'd14, 1'b1);
    drain();
    issue(3'b101, 32'd1000, 32'd3, 32'd0, 1'b0);
    repeat (21) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midop_rst_busy", busy, 0);
    chk("midop_rst_resp", resp_valid, 0);
    chk("midop_rst_result", MDResult, 0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_midop_rst", req_ready, 1);
    issue(3'b101, 32'd9, 32'd3, 32'd3, 1'b1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
